// File: rtl/up_regfile_pkg.sv
// rtl/up_regfile_pkg.sv - register map, STATUS/CONTROL bit indices and address decode for up_regfile
package up_regfile_pkg;

  localparam int unsigned REG_RX_ADDR = 32'h0;
  localparam int unsigned REG_STATUS  = 32'h8;
  localparam int unsigned REG_CONTROL = 32'hC;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_MSB = 15;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEADDEAD;

  typedef enum logic [1:0] {
    SEL_RX,
    SEL_STATUS,
    SEL_CONTROL,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode(input logic [31:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr == REG_RX_ADDR) sel = SEL_RX;
    else if (addr == REG_STATUS) sel = SEL_STATUS;
    else if (addr == REG_CONTROL) sel = SEL_CONTROL;
    return sel;
  endfunction

endpackage

// File: rtl/up_regfile_fifo.sv
// rtl/up_regfile_fifo.sv - synchronous byte FIFO with registered pointers and full/empty/level outputs
module up_regfile_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         push,
  input  logic [7:0]   push_data,
  input  logic         pop,
  output logic [7:0]   pop_data,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] level
);

  localparam int LEVEL_W = PTR_W + 1;

  logic [7:0]   mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic         do_push;
  logic         do_pop;

  // One extra pointer bit distinguishes full from empty; wrap is natural modulo 2*DEPTH.
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (level == LEVEL_W'(DEPTH));
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/up_regfile.sv
// rtl/up_regfile.sv - uP register file (RX FIFO pop, STATUS, CONTROL, ADDRESS); irq port under UP_REGFILE_IRQ_EN
module up_regfile
  import up_regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     up_rreq,
  output logic                     up_rack,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [8*BUS_WIDTH-1:0]   up_rdata,
  input  logic                     up_wreq,
  output logic                     up_wack,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [8*BUS_WIDTH-1:0]   up_wdata,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [8*BUS_WIDTH-1:0]   ctrl_out,
  output logic [8*BUS_WIDTH-1:0]   addr_out
`ifdef UP_REGFILE_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int DATA_W = 8 * BUS_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  logic              rd_take;
  logic              wr_take;
  reg_sel_e          rd_sel;
  reg_sel_e          wr_sel_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] rd_value;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0] addr_q;
  logic              overrun;
  logic              flush;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_rdata;
  logic [PTR_W:0]    fifo_level;

  // A request seen while its own ack is high is the tail of the access just served.
  assign rd_take = up_rreq && !up_rack;
  assign wr_take = up_wreq && !up_wack && !rd_take;
  assign rd_sel  = decode(32'(up_raddr));

  assign fifo_pop = rd_take && (rd_sel == SEL_RX) && !fifo_empty;
  assign flush    = up_wack && (wr_sel_q == SEL_CONTROL) && wr_data_q[CTRL_FLUSH];
  assign rx_ready = !fifo_full;
  assign ctrl_out = ctrl_q;
  assign addr_out = addr_q;

  up_regfile_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (rx_valid && rx_ready),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_NOT_EMPTY] = !fifo_empty;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_OVERRUN]   = overrun;
    status_word[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = 8'(fifo_level);
  end

  always_comb begin
    rd_value = UNMAPPED_RDATA;
    case (rd_sel)
      SEL_RX:      rd_value = fifo_empty ? '0 : {24'h0, fifo_rdata};
      SEL_STATUS:  rd_value = status_word;
      SEL_CONTROL: rd_value = ctrl_q;
      default:     rd_value = UNMAPPED_RDATA;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_rack  <= 1'b0;
      up_rdata <= '0;
    end else begin
      up_rack <= rd_take;
      if (rd_take) up_rdata <= rd_value;
    end
  end

  // Writes are captured with the ack and applied on the edge that ends the ack cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_wack   <= 1'b0;
      wr_sel_q  <= SEL_NONE;
      wr_data_q <= '0;
      ctrl_q    <= '0;
      addr_q    <= '0;
    end else begin
      up_wack <= wr_take;
      if (wr_take) begin
        wr_sel_q  <= decode(32'(up_waddr));
        wr_data_q <= up_wdata;
      end
      if (up_wack) begin
        case (wr_sel_q)
          SEL_RX:      addr_q <= wr_data_q;
          SEL_CONTROL: begin
            ctrl_q             <= wr_data_q;
            ctrl_q[CTRL_FLUSH] <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) overrun <= 1'b0;
    else if (rx_valid && !rx_ready) overrun <= 1'b1;
    else if (flush || (rd_take && rd_sel == SEL_STATUS)) overrun <= 1'b0;
  end

`ifdef UP_REGFILE_IRQ_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq <= 1'b0;
    else irq <= ctrl_q[CTRL_IRQ_EN] && (!fifo_empty || overrun);
  end
`endif

endmodule

// File: tb/tb_up_regfile.sv
// tb/tb_up_regfile.sv - randomized self-checking bench for up_regfile against a queue-based register model
module tb_up_regfile;

  localparam int DEPTH = 16;

  logic        tb_data_clk;
  logic        rstn;
  logic        up_rreq;
  logic        up_rack;
  logic [15:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_wreq;
  logic        up_wack;
  logic [15:0] up_waddr;
  logic [31:0] up_wdata;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] ctrl_out;
  logic [31:0] addr_out;
`ifdef UP_REGFILE_IRQ_EN
  logic        irq;
`endif

  up_regfile dut (
    .clk      (tb_data_clk),
    .rstn     (rstn),
    .up_rreq  (up_rreq),
    .up_rack  (up_rack),
    .up_raddr (up_raddr),
    .up_rdata (up_rdata),
    .up_wreq  (up_wreq),
    .up_wack  (up_wack),
    .up_waddr (up_waddr),
    .up_wdata (up_wdata),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .ctrl_out (ctrl_out),
    .addr_out (addr_out)
`ifdef UP_REGFILE_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial tb_data_clk = 1'b0;
  always #5 tb_data_clk = ~tb_data_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m_q[$];
  logic        m_ovr;
  logic [31:0] m_ctrl;
  logic [31:0] m_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge tb_data_clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovr  = 1'b0;
    m_ctrl = '0;
    m_addr = '0;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0] = (m_q.size() != 0);
    s[1] = (m_q.size() == DEPTH);
    s[2] = m_ovr;
    s[15:8] = 8'(m_q.size());
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [31:0] v;
    case (a)
      16'h0: v = (m_q.size() != 0) ? {24'h0, m_q.pop_front()} : 32'h0;
      16'h8: begin v = model_status(); m_ovr = 1'b0; end
      16'hC: v = m_ctrl;
      default: v = 32'hDEADDEAD;
    endcase
    return v;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d);
    if (a == 16'h0) m_addr = d;
    else if (a == 16'hC) begin
      m_ctrl = d & ~32'h1;
      if (d[0]) begin
        m_q.delete();
        m_ovr = 1'b0;
      end
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    check_eq("rx_ready", 32'(rx_ready), 32'(m_q.size() < DEPTH));
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic up_read(input string tag, input logic [15:0] a);
    int n;
    logic [31:0] exp;
    logic [31:0] d;
    exp = model_read(a);
    up_raddr = a;
    up_rreq  = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!up_rack && n < 8);
    check_eq({tag, "_rack_latency"}, 32'(n), 32'd1);
    d = up_rdata;
    check_eq({tag, "_rdata"}, d, exp);
    up_rreq = 1'b0;
    cyc();
    check_eq({tag, "_rack_once"}, 32'(up_rack), 32'd0);
    check_eq({tag, "_rdata_hold"}, up_rdata, d);
  endtask

  task automatic up_write(input logic [15:0] a, input logic [31:0] d);
    int n;
    up_waddr = a;
    up_wdata = d;
    up_wreq  = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!up_wack && n < 8);
    check_eq("wack_latency", 32'(n), 32'd1);
    up_wreq = 1'b0;
    check_eq("ctrl_before_update", ctrl_out, m_ctrl);
    check_eq("addr_before_update", addr_out, m_addr);
    model_write(a, d);
    cyc();
    check_eq("wack_once", 32'(up_wack), 32'd0);
    check_eq("ctrl_out", ctrl_out, m_ctrl);
    check_eq("addr_out", addr_out, m_addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addrs[5];
    logic [31:0] d;
    logic [31:0] exp;
    int op;

    rstn = 1'b0; up_rreq = 0; up_wreq = 0; up_raddr = 0; up_waddr = 0;
    up_wdata = 0; rx_data = 0; rx_valid = 0;
    model_reset();
    cyc(); cyc();
    check_eq("rst_rack", 32'(up_rack), 32'd0);
    check_eq("rst_wack", 32'(up_wack), 32'd0);
    check_eq("rst_rdata", up_rdata, 32'd0);
    check_eq("rst_ctrl", ctrl_out, 32'd0);
    check_eq("rst_addr", addr_out, 32'd0);
    rstn = 1'b1;
    cyc();
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
    up_read("rst_status", 16'h8);

    rx_push(8'hA5);
    rx_push(8'h3C);
    up_read("pop_a5", 16'h0);
    up_read("pop_3c", 16'h0);
    up_read("pop_empty", 16'h0);

    up_write(16'hC, 32'h12345678);
    up_read("ctrl_rb", 16'hC);
    rx_push(8'h11);
    up_write(16'hC, 32'h00000001);
    up_read("ctrl_flush_rb", 16'hC);
    up_read("flush_status", 16'h8);

    for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom));
    rx_push(8'hEE);
    up_read("full_status1", 16'h8);
    up_read("full_status2", 16'h8);

    d = $urandom;
    exp = model_read(16'h8);
    up_raddr = 16'h8; up_waddr = 16'h0; up_wdata = d;
    up_rreq = 1'b1; up_wreq = 1'b1;
    cyc();
    check_eq("sim_rack", 32'(up_rack), 32'd1);
    check_eq("sim_wack_wait", 32'(up_wack), 32'd0);
    check_eq("sim_rdata", up_rdata, exp);
    up_rreq = 1'b0;
    cyc();
    check_eq("sim_rack_low", 32'(up_rack), 32'd0);
    check_eq("sim_wack", 32'(up_wack), 32'd1);
    up_wreq = 1'b0;
    model_write(16'h0, d);
    cyc();
    check_eq("sim_wack_low", 32'(up_wack), 32'd0);
    check_eq("sim_addr_out", addr_out, m_addr);

    up_read("unmapped_4", 16'h4);
    up_write(16'h4, $urandom);

`ifdef UP_REGFILE_IRQ_EN
    up_write(16'hC, 32'h1);
    up_write(16'hC, 32'h2);
    rx_push(8'h5A);
    cyc();
    check_eq("irq_high", 32'(irq), 32'd1);
    up_read("irq_pop", 16'h0);
    cyc();
    check_eq("irq_low", 32'(irq), 32'd0);
`endif

    rx_push(8'h77);
    up_raddr = 16'h0;
    up_rreq  = 1'b1;
    #2 rstn = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("midrst_no_rack", 32'(up_rack), 32'd0);
    end
    up_rreq = 1'b0;
    rstn = 1'b1;
    cyc();
    check_eq("midrst_no_rack_after", 32'(up_rack), 32'd0);
    up_read("midrst_status", 16'h8);

    for (int it = 0; it < 400; it++) begin
      addrs[0] = 16'h0; addrs[1] = 16'h8; addrs[2] = 16'hC; addrs[3] = 16'h4;
      addrs[4] = 16'($urandom);
      op = $urandom_range(2);
      if (op == 0) begin
        for (int k = 0; k < $urandom_range(1, 7); k++) rx_push(8'($urandom));
      end else if (op == 1) begin
        up_read("rnd_read", addrs[$urandom_range(4)]);
      end else begin
        d = $urandom;
        if ($urandom_range(3) != 0) d[0] = 1'b0;
        up_write(addrs[$urandom_range(4)], d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
